node_succ_iter: RTL and testbench
=================================

Name: node_succ_iter

Overview:
- Parametrised successor node for the recursive-function datapath: computes RES = IN + CNT by applying the successor operation once per clock, CNT times.
- Keeps the established node handshake: a rising edge on ST starts an operation; RD=1 means idle or result valid.
- Adds configurable operand width, a per-operation step count, an overflow flag and a selectable wrap/saturate mode.
- Sits wherever a chain of successor nodes or a bounded iteration would otherwise be instantiated.

Parameters:
- WIDTH, 16, bit width of IN, RES and the internal accumulator.
- CNT_WIDTH, 8, bit width of the CNT step-count input.
- SATURATE, 0, overflow mode: 0 = wrap modulo 2^WIDTH; 1 = hold at 2^WIDTH-1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- ST  input  1  start request; only a 0->1 transition sampled on CLK counts.
- IN  input  WIDTH  operand; sampled at the start edge only.
- CNT  input  CNT_WIDTH  number of successor steps; sampled at the start edge only.
- RD  output  1  ready/done: 1 = idle and RES valid; 0 = busy.
- RES  output  WIDTH  result register.
- OVF  output  1  1 if any step overflowed during the last operation.

Behaviour:
- Registers:
  - st_q: previous ST.
  - state: IDLE or RUN.
  - acc: WIDTH bits.
  - rem: CNT_WIDTH bits.
  - RD, RES, OVF.
- st_q <= ST on every clock edge, including while RST=1. As a result, ST held high through reset release does not start an operation.
- Reset (RST=1 at the edge): state=IDLE, RD=1, RES=0, OVF=0, acc=0, rem=0. A reset during RUN aborts the operation and discards the partial result.
- Start condition: RST=0, state=IDLE, ST=1 and st_q=0. On that edge:
  - acc<=IN, rem<=CNT, OVF<=0, RD<=0, state<=RUN.
  - RES keeps its previous value.
- RUN with rem!=0, at each edge:
  - rem<=rem-1.
  - If acc != 2^WIDTH-1: acc<=acc+1.
  - If acc == 2^WIDTH-1: OVF<=1 (sticky for the rest of the operation), and acc<=0 when SATURATE=0, or acc holds at 2^WIDTH-1 when SATURATE=1.
- RUN with rem==0, at the edge: RES<=acc, RD<=1, state<=IDLE.
- Latency:
  - Start edge at cycle k gives RD=1 and RES valid after edge k+CNT+1.
  - CNT=0 gives RES=IN after edge k+1.
  - RD is low for exactly CNT+1 cycles.
- ST edges during RUN are ignored and are not queued. st_q still tracks ST, so a pulse that rises during RUN is lost.
- A new start on the same edge that RD returns to 1 is not possible. The earliest restart is the edge after the RD=1 edge, provided a fresh 0->1 edge on ST is present there.
- OVF and RES stay stable in IDLE until the next start (OVF clears at start) or reset.
- Arithmetic is unsigned. No carry-out port exists; OVF is the only overflow indication.
- Maximum RD-low time is 2^CNT_WIDTH cycles (CNT = all ones).

Test Plan:
- Basic (WIDTH=16): after reset, check RD=1, RES=0, OVF=0. Then IN=5, CNT=3, pulse ST one cycle -> RD=0 for 4 cycles, then RD=1, RES=8, OVF=0.
- Zero count: IN=0x1234, CNT=0, ST edge -> RD low 1 cycle, RES=0x1234, OVF=0.
- Wrap (SATURATE=0): IN=0xFFFE, CNT=4 -> RES=0x0002, OVF=1. A following run with IN=1, CNT=1 -> RES=2, OVF=0.
- Saturate (SATURATE=1): IN=0xFFFE, CNT=4 -> RES=0xFFFF, OVF=1. Also WIDTH=8, IN=0xFF, CNT=1 -> RES=0xFF, OVF=1.
- Edge rules:
  - ST held high for 20 cycles with IN=1, CNT=2 -> exactly one operation, RES=3.
  - A second ST pulse mid-RUN -> ignored, RES=3.
  - ST high across reset release -> no start.
- Reset mid-operation: IN=10, CNT=100, assert RST at cycle 50 -> next edge RD=1, RES=0, OVF=0. A new start with IN=7, CNT=1 -> RES=8.

Source files
------------

// File: rtl/node_succ_iter_if.sv
// Handshake bundle for the successor node: start/operand/count in, ready/result/overflow out.
// No latency of its own; pure wiring between producer and node.
// No backpressure; the producer must wait for RD=1 before issuing a new start.
interface node_succ_iter_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 ST;
  logic [WIDTH-1:0]     IN;
  logic [CNT_WIDTH-1:0] CNT;
  logic                 RD;
  logic [WIDTH-1:0]     RES;
  logic                 OVF;

  // Producer side: issues start and operands, observes completion.
  modport master (
    output ST, IN, CNT,
    input  RD, RES, OVF
  );

  // Node side: consumes start and operands, reports completion.
  modport slave (
    input  ST, IN, CNT,
    output RD, RES, OVF
  );
endinterface

// File: rtl/node_succ_iter.sv
// Successor node: RES = IN + CNT, one increment per clock, with wrap or saturate on overflow.
// Latency: RD drops on the start edge and returns CNT+1 edges later with RES valid.
// No queueing: start edges seen while busy are dropped; caller waits for RD=1.
module node_succ_iter #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE  = 0
) (
  input  logic              CLK,
  input  logic              RST,
  node_succ_iter_if.slave   bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_st_q;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic [CNT_WIDTH-1:0] r_rem;
  logic [CNT_WIDTH-1:0] w_rem_nxt;
  logic                 r_rd;
  logic                 w_rd_nxt;
  logic [WIDTH-1:0]     r_res;
  logic [WIDTH-1:0]     w_res_nxt;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic                 w_start;

  // Previous ST is tracked even through reset so a level held across reset release is not a start.
  always_ff @(posedge CLK) begin
    r_st_q <= bus.ST;
  end

  assign w_start = bus.ST & ~r_st_q;

  // State register with synchronous reset; a reset during RUN discards the partial result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_rd    <= 1'b1;
      r_res   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_rd    <= w_rd_nxt;
      r_res   <= w_res_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state logic: capture operands on start, step the accumulator while steps remain, then publish.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_rd_nxt    = r_rd;
    w_res_nxt   = r_res;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_acc_nxt   = bus.IN;
          w_rem_nxt   = bus.CNT;
          w_ovf_nxt   = 1'b0;
          w_rd_nxt    = 1'b0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_rem != '0) begin
          w_rem_nxt = r_rem - CNT_WIDTH'(1);
          if (r_acc != ACC_MAX) begin
            w_acc_nxt = r_acc + WIDTH'(1);
          end else begin
            // Overflow is sticky for the rest of the operation.
            w_ovf_nxt = 1'b1;
            w_acc_nxt = (SATURATE != 0) ? ACC_MAX : '0;
          end
        end else begin
          w_res_nxt   = r_acc;
          w_rd_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.RD  = r_rd;
  assign bus.RES = r_res;
  assign bus.OVF = r_ovf;

endmodule

// File: tb/tb_node_succ_iter.sv
module tb_node_succ_iter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  st;
  logic [15:0] in_v;
  logic [7:0]  cnt_v;

  always #5 CLK = ~CLK;

  // dut 0: 16-bit wrap, dut 1: 16-bit saturate, dut 2: 8-bit saturate
  node_succ_iter_if #(.WIDTH(16), .CNT_WIDTH(8)) if0 ();
  node_succ_iter_if #(.WIDTH(16), .CNT_WIDTH(8)) if1 ();
  node_succ_iter_if #(.WIDTH(8),  .CNT_WIDTH(8)) if2 ();

  assign if0.ST  = st[0];
  assign if0.IN  = in_v;
  assign if0.CNT = cnt_v;
  assign if1.ST  = st[1];
  assign if1.IN  = in_v;
  assign if1.CNT = cnt_v;
  assign if2.ST  = st[2];
  assign if2.IN  = in_v[7:0];
  assign if2.CNT = cnt_v;

  node_succ_iter #(.WIDTH(16), .CNT_WIDTH(8), .SATURATE(0)) u_wrap16 (.CLK(CLK), .RST(RST), .bus(if0));
  node_succ_iter #(.WIDTH(16), .CNT_WIDTH(8), .SATURATE(1)) u_sat16  (.CLK(CLK), .RST(RST), .bus(if1));
  node_succ_iter #(.WIDTH(8),  .CNT_WIDTH(8), .SATURATE(1)) u_sat8   (.CLK(CLK), .RST(RST), .bus(if2));

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          low;
  } exp_t;

  typedef struct {
    int          dut;
    logic [15:0] in;
    logic [7:0]  cnt;
    logic [15:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic get_out(input int d, output logic rd, output logic [15:0] res, output logic ovf);
    case (d)
      0:       begin rd = if0.RD; res = if0.RES;           ovf = if0.OVF; end
      1:       begin rd = if1.RD; res = if1.RES;           ovf = if1.OVF; end
      default: begin rd = if2.RD; res = {8'h00, if2.RES}; ovf = if2.OVF; end
    endcase
  endtask

  // Entered at a negedge with all ST low; returns at the negedge after RD rises.
  task automatic run_op(input int d, input logic [15:0] in, input logic [7:0] cnt,
                        input logic [15:0] exp_res, input logic exp_ovf, input string name);
    exp_t        e;
    int          low;
    logic        rd;
    logic [15:0] res;
    logic        ovf;
    e.res = exp_res;
    e.ovf = exp_ovf;
    e.low = int'(cnt) + 1;
    sb_q.push_back(e);
    in_v  = in;
    cnt_v = cnt;
    st[d] = 1'b1;
    @(negedge CLK);
    st[d] = 1'b0;
    low = 0;
    get_out(d, rd, res, ovf);
    while (!rd && low < 400) begin
      low++;
      @(negedge CLK);
      get_out(d, rd, res, ovf);
    end
    e = sb_q.pop_front();
    check({name, "_rd_low_cycles"}, 32'(low), 32'(e.low));
    check({name, "_res"}, {16'h0, res}, {16'h0, e.res});
    check({name, "_ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
  endtask

  initial begin
    logic        rd;
    logic [15:0] res;
    logic        ovf;
    int          low;

    vecs[0] = '{0, 16'd5,    8'd3,   16'd8,    1'b0};
    vecs[1] = '{0, 16'h1234, 8'd0,   16'h1234, 1'b0};
    vecs[2] = '{0, 16'hFFFE, 8'd4,   16'h0002, 1'b1};
    vecs[3] = '{0, 16'd1,    8'd1,   16'd2,    1'b0};
    vecs[4] = '{1, 16'hFFFE, 8'd4,   16'hFFFF, 1'b1};
    vecs[5] = '{2, 16'h00FF, 8'd1,   16'h00FF, 1'b1};
    vecs[6] = '{1, 16'hFFFD, 8'd2,   16'hFFFF, 1'b0};
    vecs[7] = '{2, 16'h0010, 8'hFF,  16'h00FF, 1'b1};
    vecs[8] = '{0, 16'hFFFF, 8'd0,   16'hFFFF, 1'b0};

    RST   = 1'b1;
    st    = 3'b000;
    in_v  = '0;
    cnt_v = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int d = 0; d < 3; d++) begin
      get_out(d, rd, res, ovf);
      check($sformatf("reset_rd_%0d", d),  {31'h0, rd},  32'h1);
      check($sformatf("reset_res_%0d", d), {16'h0, res}, 32'h0);
      check($sformatf("reset_ovf_%0d", d), {31'h0, ovf}, 32'h0);
    end

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].dut, vecs[i].in, vecs[i].cnt, vecs[i].exp_res, vecs[i].exp_ovf,
             $sformatf("vec%0d", i));
    end

    // ST held high for 20 cycles: exactly one operation.
    in_v  = 16'd1;
    cnt_v = 8'd2;
    st[0] = 1'b1;
    low   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!if0.RD) low++;
    end
    st[0] = 1'b0;
    @(negedge CLK);
    check("held_st_rd_low_cycles", 32'(low), 32'd3);
    check("held_st_res", {16'h0, if0.RES}, 32'd3);

    // Second ST pulse while busy (with a new operand) is dropped, not queued.
    st[0] = 1'b1;
    low   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) st[0] = 1'b0;
      if (i == 1) begin st[0] = 1'b1; in_v = 16'd100; end
      if (i == 2) st[0] = 1'b0;
      if (!if0.RD) low++;
    end
    check("mid_run_pulse_rd_low_cycles", 32'(low), 32'd3);
    check("mid_run_pulse_res", {16'h0, if0.RES}, 32'd3);

    // ST high across reset release must not start an operation.
    st[0] = 1'b1;
    RST   = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    low = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (!if0.RD) low++;
    end
    check("st_across_reset_rd_low_cycles", 32'(low), 32'd0);
    check("st_across_reset_res", {16'h0, if0.RES}, 32'd0);
    st[0] = 1'b0;
    @(negedge CLK);

    // Reset in the middle of a long operation aborts it.
    in_v  = 16'd10;
    cnt_v = 8'd100;
    st[0] = 1'b1;
    @(negedge CLK);
    st[0] = 1'b0;
    repeat (49) @(negedge CLK);
    check("mid_op_busy_rd", {31'h0, if0.RD}, 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_op_reset_rd",  {31'h0, if0.RD},  32'h1);
    check("mid_op_reset_res", {16'h0, if0.RES}, 32'h0);
    check("mid_op_reset_ovf", {31'h0, if0.OVF}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    run_op(0, 16'd7, 8'd1, 16'd8, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
